// File: rtl/bsg_manycore_io_req_arbiter.sv
// bsg_manycore_io_req_arbiter: round-robin, credit-gated arbiter driving one registered IO proc link (hold-grant lock under BSG_MANYCORE_IO_ARB_LOCK_EN)
module bsg_manycore_io_req_arbiter #(
  parameter int num_req_p = 4,
  parameter int packet_width_p = 128,
  parameter int max_out_credits_p = 16,
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1),
  localparam int id_width_lp = ($clog2(num_req_p) > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                v_i,
  input  logic [num_req_p*packet_width_p-1:0] packet_i,
  input  logic [num_req_p-1:0]                lock_i,
  output logic [num_req_p-1:0]                ready_o,
  output logic                                v_o,
  output logic [packet_width_p-1:0]           packet_o,
  output logic [id_width_lp-1:0]              id_o,
  input  logic                                ready_i,
  input  logic                                credit_i,
  output logic [credit_width_lp-1:0]          credits_o,
  output logic                                idle_o
);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
  logic                       v_q, v_d;
  logic [packet_width_p-1:0]  packet_q, packet_d;
  logic [id_width_lp-1:0]     id_q, id_d;
  logic [id_width_lp-1:0]     ptr_q, ptr_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic [id_width_lp-1:0]     rr_grant, idx, grant;
  logic                       found, accept, hold_ptr;
  always_comb begin
    rr_grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = id_width_lp'((int'(ptr_q) + k) % num_req_p);
      if (!found && v_i[idx]) begin
        found = 1'b1;
        rr_grant = idx;
      end
    end
  end
`ifdef BSG_MANYCORE_IO_ARB_LOCK_EN
  logic lock_vld_q, lock_vld_d;
  assign lock_vld_d = lock_vld_q | accept;
  assign grant = (lock_vld_q && v_i[id_q] && lock_i[id_q]) ? id_q : rr_grant;
  assign hold_ptr = lock_i[grant];
  always_ff @(posedge clk_i) lock_vld_q <= reset_i ? 1'b0 : lock_vld_d;
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign grant = rr_grant;
  assign hold_ptr = 1'b0;
`endif
  assign accept = !reset_i && (!v_q || ready_i) && (credits_q != '0) && found;
  always_comb begin
    ready_o = accept ? (num_req_p'(1) << grant) : '0;
    v_d = accept || (v_q && !ready_i);
    packet_d = accept ? packet_i[grant*packet_width_p +: packet_width_p] : packet_q;
    id_d = accept ? grant : id_q;
    ptr_d = (accept && !hold_ptr)
          ? ((grant == id_width_lp'(num_req_p - 1)) ? '0 : grant + id_width_lp'(1))
          : ptr_q;
    credits_d = (accept && !credit_i) ? credits_q - credit_width_lp'(1)
              : (!accept && credit_i && credits_q != max_credits_lp) ? credits_q + credit_width_lp'(1)
              : credits_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q <= 1'b0;
      packet_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
      credits_q <= max_credits_lp;
    end else begin
      v_q <= v_d;
      packet_q <= packet_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      credits_q <= credits_d;
    end
  end
  credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(credit_i && !accept && credits_q == max_credits_lp));
  assign v_o = v_q;
  assign packet_o = packet_q;
  assign id_o = id_q;
  assign credits_o = credits_q;
  assign idle_o = (credits_q == max_credits_lp) && !v_q;
endmodule
